// File: rtl/io_responder.sv
// IO-page responder: LED output, synchronised switch input and a prescaled down-counting timer.
// Reads are combinational (same cycle as ior, no backpressure); all register side effects land on the clock edge.
module io_responder #(
    parameter int PRESCALE    = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ior,
    input  logic        iow,
    input  logic [9:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic [23:0] switch_in,
    output logic [23:0] led_out,
    output logic        timer_irq
);

    localparam logic [9:0] A_LED_LO = 10'h060;
    localparam logic [9:0] A_LED_HI = 10'h062;
    localparam logic [9:0] A_SW_LO  = 10'h070;
    localparam logic [9:0] A_SW_HI  = 10'h072;
    localparam logic [9:0] A_CTRL   = 10'h020;
    localparam logic [9:0] A_STAT   = 10'h024;
    localparam logic [9:0] A_LOAD   = 10'h028;
    localparam logic [9:0] A_CNT    = 10'h02C;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [23:0]   led_q, led_d;
    logic          en_q, en_d;
    logic          reload_q, reload_d;
    logic [15:0]   load_q, load_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [23:0]   sync_q [SYNC_STAGES];
    logic [23:0]   sw_sync;
    logic          wr_ctrl;
    logic          tick;

    assign sw_sync   = sync_q[SYNC_STAGES-1];
    assign led_out   = led_q;
    assign timer_irq = done_q;
    assign wr_ctrl   = iow && (addr == A_CTRL);
    assign tick      = en_q && (pre_q == PRE_MAX);

    // Read mux reflects pre-edge state, so a combined read/write returns the old value.
    always_comb begin
        rdata = '0;
        if (ior) begin
            case (addr)
                A_LED_LO: rdata = led_q[15:0];
                A_LED_HI: rdata = {8'h00, led_q[23:16]};
                A_SW_LO:  rdata = sw_sync[15:0];
                A_SW_HI:  rdata = {8'h00, sw_sync[23:16]};
                A_CTRL:   rdata = {14'd0, reload_q, en_q};
                A_STAT:   rdata = {14'd0, en_q, done_q};
                A_LOAD:   rdata = load_q;
                A_CNT:    rdata = cnt_q;
                default:  rdata = '0;
            endcase
        end
    end

    always_comb begin
        led_d    = led_q;
        en_d     = en_q;
        reload_d = reload_q;
        load_d   = load_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        pre_d    = pre_q;

        if (iow && addr == A_LED_LO) led_d[15:0]  = wdata;
        if (iow && addr == A_LED_HI) led_d[23:16] = wdata[7:0];
        if (iow && addr == A_LOAD)   load_d       = wdata;

        // Clear-on-read comes first so a same-cycle expiry can override it.
        if (ior && addr == A_STAT) done_d = 1'b0;

        if (wr_ctrl && !wdata[0]) begin
            en_d     = 1'b0;
            reload_d = wdata[1];
        end else if (wr_ctrl && !en_q) begin
            en_d     = 1'b1;
            reload_d = wdata[1];
            cnt_d    = load_q;
            pre_d    = '0;
        end else begin
            if (wr_ctrl) reload_d = wdata[1];
            if (en_q) begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (tick) begin
                    if (cnt_q > 16'd1) begin
                        cnt_d = cnt_q - 16'd1;
                    end else begin
                        done_d = 1'b1;
                        if (reload_q) begin
                            cnt_d = load_q;
                        end else begin
                            cnt_d = '0;
                            en_d  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q    <= '0;
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            load_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            pre_q    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            led_q    <= led_d;
            en_q     <= en_d;
            reload_q <= reload_d;
            load_q   <= load_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            pre_q    <= pre_d;
            sync_q[0] <= switch_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: reads push expectations into a scoreboard, a monitor compares on ior.
module tb_io_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        ior;
    logic        iow;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [23:0] switch_in;
    logic [23:0] led_out;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;

    string       exp_name [$];
    logic [15:0] exp_val  [$];

    io_responder #(.PRESCALE(4), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .ior       (ior),
        .iow       (iow),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .switch_in (switch_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    always #5 clock = ~clock;

    // Monitor: every cycle with ior high consumes one expected read value.
    always @(negedge clock) begin
        if (ior === 1'b1) begin
            checks++;
            if (exp_val.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: addr=0x%03h rdata=0x%04h, no expectation queued", addr, rdata);
            end else begin
                string       n;
                logic [15:0] e;
                n = exp_name.pop_front();
                e = exp_val.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL %s: rdata=0x%04h expected 0x%04h", n, rdata, e);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", n, act, exp);
        end
    endtask

    // Each bus task occupies exactly one cycle, starting and ending 1ns after a rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
        ior = 1'b0;
        iow = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d);
        addr = a; wdata = d; iow = 1'b1;
        cyc();
    endtask

    task automatic rd(input string n, input logic [9:0] a, input logic [15:0] e);
        exp_name.push_back(n);
        exp_val.push_back(e);
        addr = a; ior = 1'b1;
        cyc();
    endtask

    task automatic rdwr(input string n, input logic [9:0] a, input logic [15:0] d, input logic [15:0] e);
        exp_name.push_back(n);
        exp_val.push_back(e);
        addr = a; wdata = d; ior = 1'b1; iow = 1'b1;
        cyc();
    endtask

    initial begin
        reset = 1'b1; ior = 1'b0; iow = 1'b0;
        addr = '0; wdata = '0; switch_in = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        rd("rst_led_lo", 10'h060, 16'h0000);
        rd("rst_cnt",    10'h02C, 16'h0000);
        rd("rst_stat",   10'h024, 16'h0000);
        rd("rst_ctrl",   10'h020, 16'h0000);
        chk("rst_led_out", led_out, 24'h000000);
        chk("rst_irq", {23'd0, timer_irq}, 24'd0);

        // LEDs
        wr(10'h060, 16'hA5A5);
        wr(10'h062, 16'h00FF);
        chk("led_out_ffa5a5", led_out, 24'hFFA5A5);
        rd("led_hi", 10'h062, 16'h00FF);
        rd("led_lo", 10'h060, 16'hA5A5);
        wr(10'h062, 16'hABCD);
        rd("led_hi_upper_zero", 10'h062, 16'h00CD);

        // Switch synchroniser: value visible two edges after the pins change
        switch_in = 24'h123456;
        rd("sw_lo_lag0", 10'h070, 16'h0000);
        rd("sw_lo_lag1", 10'h070, 16'h0000);
        rd("sw_lo",      10'h070, 16'h3456);
        rd("sw_hi",      10'h072, 16'h0012);

        // Unmapped address and combined read/write
        rd("unmapped_rd", 10'h040, 16'h0000);
        wr(10'h040, 16'hFFFF);
        rd("unmapped_wr_led", 10'h060, 16'hA5A5);
        rd("unmapped_wr_load", 10'h028, 16'h0000);
        rd("unmapped_wr_ctrl", 10'h020, 16'h0000);
        rdwr("rdwr_old", 10'h060, 16'h1234, 16'hA5A5);
        chk("rdwr_led_new", led_out, 24'hCD1234);

        // One-shot: LOAD=3, prescale 4 -> DONE 12 cycles after the start edge
        wr(10'h028, 16'd3);
        rd("load_rb", 10'h028, 16'd3);
        wr(10'h020, 16'h0001);
        idle(11);
        chk("oneshot_irq_early", {23'd0, timer_irq}, 24'd0);
        rd("oneshot_cnt1", 10'h02C, 16'd1);
        chk("oneshot_irq", {23'd0, timer_irq}, 24'd1);
        rd("oneshot_cnt0", 10'h02C, 16'd0);
        rd("oneshot_ctrl", 10'h020, 16'h0000);
        rd("oneshot_stat", 10'h024, 16'h0001);
        rd("stat_cleared", 10'h024, 16'h0000);
        chk("irq_cleared", {23'd0, timer_irq}, 24'd0);

        // Auto-reload: LOAD=2, CTRL=3 -> expiry every 8 cycles
        wr(10'h028, 16'd2);
        wr(10'h020, 16'h0003);
        idle(7);
        chk("reload_irq_early", {23'd0, timer_irq}, 24'd0);
        idle(1);
        chk("reload_irq", {23'd0, timer_irq}, 24'd1);
        rd("reload_cnt", 10'h02C, 16'd2);
        rd("reload_stat", 10'h024, 16'h0003);
        chk("reload_irq_clr", {23'd0, timer_irq}, 24'd0);
        rd("reload_stat_clr", 10'h024, 16'h0002);
        idle(4);
        // STAT read in the expiry cycle: old DONE returned, set wins
        rd("stat_on_expiry", 10'h024, 16'h0002);
        chk("expiry_set_wins", {23'd0, timer_irq}, 24'd1);
        rd("stat_after_expiry", 10'h024, 16'h0003);
        idle(5);
        rd("cnt_before_reset", 10'h02C, 16'd1);

        // Reset mid-count
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        chk("midreset_irq", {23'd0, timer_irq}, 24'd0);
        rd("midreset_cnt",  10'h02C, 16'd0);
        rd("midreset_ctrl", 10'h020, 16'h0000);
        chk("midreset_led", led_out, 24'h000000);

        // Stop while running: CNT holds
        wr(10'h028, 16'd5);
        wr(10'h020, 16'h0001);
        idle(4);
        wr(10'h020, 16'h0000);
        idle(10);
        rd("stop_cnt_hold", 10'h02C, 16'd4);
        rd("stop_stat", 10'h024, 16'h0000);

        checks++;
        if (exp_val.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_val.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
